// File: rtl/sub_bytes_sched.sv
// sub_bytes_sched: arbitrates a state requester and a key-word requester onto one registered AES S-box

// sub_byte: registered AES S-box, enc_en_i=1 forward, enc_en_i=0 inverse
module sub_byte (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enc_en_i,
    input  logic [7:0] byte_i,
    output logic [7:0] byte_o
);
    logic [7:0] aff_inv;
    logic [7:0] sbox_d;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = a;
        for (int i = 1; i < 8; i++) begin
            p = gmul(p, p);
            r = gmul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] a, input int n);
        return (a << n) | (a >> (8 - n));
    endfunction

    assign aff_inv = rotl(byte_i, 1) ^ rotl(byte_i, 3) ^ rotl(byte_i, 6) ^ 8'h05;

    // forward: inverse then affine; inverse: inverse-affine then inverse
    always_comb begin
        sbox_d = enc_en_i ? ginv(byte_i) : ginv(aff_inv);
        sbox_d = enc_en_i ? (sbox_d ^ rotl(sbox_d, 1) ^ rotl(sbox_d, 2) ^ rotl(sbox_d, 3)
                             ^ rotl(sbox_d, 4) ^ 8'h63) : sbox_d;
    end

    // one-cycle output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) byte_o <= '0;
        else        byte_o <= sbox_d;
    end
endmodule

module sub_bytes_sched (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         st_valid,
    output logic         st_ready,
    input  logic [127:0] st_in,
    input  logic         st_dec,
    output logic         st_done,
    output logic [127:0] st_out,
    input  logic         kw_valid,
    output logic         kw_ready,
    input  logic [31:0]  kw_in,
    output logic         kw_done,
    output logic [31:0]  kw_out,
    output logic         busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;

    state_e       state_q;
    logic [127:0] data_q;
    logic [127:0] res_q;
    logic [127:0] st_out_q;
    logic [31:0]  kw_out_q;
    logic [3:0]   cnt_q;
    logic [3:0]   wr_idx_q;
    logic [3:0]   last;
    logic         own_st_q;
    logic         mode_q;
    logic         prio_st_q;
    logic         wr_q;
    logic         st_done_q;
    logic         kw_done_q;
    logic [7:0]   sb_out;

    assign last     = own_st_q ? 4'd15 : 4'd3;
    assign st_ready = rst_n && state_q == IDLE && st_valid && (!kw_valid || prio_st_q);
    assign kw_ready = rst_n && state_q == IDLE && kw_valid && (!st_valid || !prio_st_q);
    assign busy     = state_q != IDLE;
    assign st_done  = st_done_q;
    assign kw_done  = kw_done_q;
    assign st_out   = st_out_q;
    assign kw_out   = kw_out_q;

    sub_byte u_sbox (
        .clk      (clk),
        .rst_n    (rst_n),
        .enc_en_i (!mode_q),
        .byte_i   (data_q[{cnt_q, 3'b000} +: 8]),
        .byte_o   (sb_out)
    );

    // job FSM: accept, issue one byte per cycle, drain the S-box, publish result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            data_q    <= '0;
            res_q     <= '0;
            st_out_q  <= '0;
            kw_out_q  <= '0;
            cnt_q     <= '0;
            wr_idx_q  <= '0;
            own_st_q  <= 1'b0;
            mode_q    <= 1'b0;
            prio_st_q <= 1'b0;
            wr_q      <= 1'b0;
            st_done_q <= 1'b0;
            kw_done_q <= 1'b0;
        end else begin
            st_done_q <= 1'b0;
            kw_done_q <= 1'b0;
            wr_q      <= state_q == ISSUE;
            wr_idx_q  <= cnt_q;
            if (wr_q) res_q[{wr_idx_q, 3'b000} +: 8] <= sb_out;
            case (state_q)
                IDLE: if (st_ready || kw_ready) begin
                    data_q    <= st_ready ? st_in : {96'd0, kw_in};
                    own_st_q  <= st_ready;
                    mode_q    <= st_ready && st_dec;
                    prio_st_q <= !st_ready;
                    cnt_q     <= '0;
                    state_q   <= ISSUE;
                end
                ISSUE: begin
                    cnt_q <= cnt_q + 4'd1;
                    if (cnt_q == last) state_q <= DRAIN;
                end
                DRAIN: state_q <= DONE;
                DONE: begin
                    if (own_st_q) begin
                        st_out_q  <= res_q;
                        st_done_q <= 1'b1;
                    end else begin
                        kw_out_q  <= res_q[31:0];
                        kw_done_q <= 1'b1;
                    end
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sub_bytes_sched.sv
// tb_sub_bytes_sched: scoreboard bench for the shared S-box scheduler
module tb_sub_bytes_sched;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         st_valid = 1'b0;
    logic         st_ready;
    logic [127:0] st_in = '0;
    logic         st_dec = 1'b0;
    logic         st_done;
    logic [127:0] st_out;
    logic         kw_valid = 1'b0;
    logic         kw_ready;
    logic [31:0]  kw_in = '0;
    logic         kw_done;
    logic [31:0]  kw_out;
    logic         busy;

    int errs = 0;
    int checks = 0;
    int cyc = 0;
    int st_acc = 0;

    logic [7:0]   fwd_t [256];
    logic [7:0]   inv_t [256];
    logic [127:0] st_q [$];
    int           st_t [$];
    logic [31:0]  kw_q [$];
    int           kw_t [$];
    int           kw_done_log [$];
    logic         grants [$];
    logic [127:0] st_last = '0;
    logic [31:0]  kw_last = '0;
    logic         prio_st = 1'b0;
    logic         active = 1'b0;
    logic [127:0] m_exp;
    int           m_t;
    logic         e_st;
    logic         e_kw;

    sub_bytes_sched dut (
        .clk(clk), .rst_n(rst_n),
        .st_valid(st_valid), .st_ready(st_ready), .st_in(st_in), .st_dec(st_dec),
        .st_done(st_done), .st_out(st_out),
        .kw_valid(kw_valid), .kw_ready(kw_ready), .kw_in(kw_in),
        .kw_done(kw_done), .kw_out(kw_out), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // polynomial product reduced modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h11b << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [7:0] affine(input logic [7:0] a);
        logic [7:0] b;
        logic [7:0] c;
        c = 8'h63;
        for (int i = 0; i < 8; i++)
            b[i] = a[i] ^ a[(i + 4) % 8] ^ a[(i + 5) % 8] ^ a[(i + 6) % 8] ^ a[(i + 7) % 8] ^ c[i];
        return b;
    endfunction

    function automatic logic [127:0] st_model(input logic [127:0] d, input logic dec);
        logic [127:0] r;
        for (int k = 0; k < 16; k++) r[8*k +: 8] = dec ? inv_t[d[8*k +: 8]] : fwd_t[d[8*k +: 8]];
        return r;
    endfunction

    function automatic logic [31:0] kw_model(input logic [31:0] d);
        logic [31:0] r;
        for (int k = 0; k < 4; k++) r[8*k +: 8] = fwd_t[d[8*k +: 8]];
        return r;
    endfunction

    task automatic st_job(input logic [127:0] d, input logic dec, input logic [127:0] exp);
        st_in = d;
        st_dec = dec;
        st_valid = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (st_ready) begin
                st_q.push_back(exp);
                st_t.push_back(cyc + 1);
                st_acc = cyc + 1;
                @(posedge clk);
                #1;
                st_valid = 1'b0;
                st_in = {$urandom, $urandom, $urandom, $urandom};
                st_dec = ~st_dec;
                return;
            end
        end
        st_valid = 1'b0;
        chk("st_accept_timeout", 0, 1);
    endtask

    task automatic kw_job(input logic [31:0] d, input logic [31:0] exp);
        kw_in = d;
        kw_valid = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (kw_ready) begin
                kw_q.push_back(exp);
                kw_t.push_back(cyc + 1);
                @(posedge clk);
                #1;
                kw_valid = 1'b0;
                kw_in = $urandom;
                return;
            end
        end
        kw_valid = 1'b0;
        chk("kw_accept_timeout", 0, 1);
    endtask

    task automatic drain();
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (!busy && st_q.size() == 0 && kw_q.size() == 0) return;
        end
        chk("drain_timeout", 0, 1);
    endtask

    // monitor: scoreboard pops, arbitration and busy model
    always @(negedge clk) begin
        if (!rst_n) begin
            st_q.delete();
            st_t.delete();
            kw_q.delete();
            kw_t.delete();
            kw_done_log.delete();
            grants.delete();
            st_last = '0;
            kw_last = '0;
            prio_st = 1'b0;
            active = 1'b0;
        end else begin
            if (st_done) begin
                if (st_q.size() == 0) chk("st_done_spurious", 1, 0);
                else begin
                    m_exp = st_q.pop_front();
                    m_t = st_t.pop_front();
                    chk("st_out", st_out, m_exp);
                    chk("st_latency", cyc - m_t, 18);
                    chk("kw_out_held", kw_out, kw_last);
                    st_last = m_exp;
                end
                active = 1'b0;
            end
            if (kw_done) begin
                if (kw_q.size() == 0) chk("kw_done_spurious", 1, 0);
                else begin
                    m_exp = kw_q.pop_front();
                    m_t = kw_t.pop_front();
                    chk("kw_out", kw_out, m_exp);
                    chk("kw_latency", cyc - m_t, 6);
                    chk("st_out_held", st_out, st_last);
                    kw_last = m_exp[31:0];
                end
                kw_done_log.push_back(cyc);
                active = 1'b0;
            end
            chk("busy", busy, active);
            e_st = 1'b0;
            e_kw = 1'b0;
            if (!active) begin
                if (st_valid && kw_valid) begin
                    if (prio_st) e_st = 1'b1;
                    else e_kw = 1'b1;
                end else begin
                    e_st = st_valid;
                    e_kw = kw_valid;
                end
            end
            chk("st_ready", st_ready, e_st);
            chk("kw_ready", kw_ready, e_kw);
            if (st_valid && st_ready) begin
                prio_st = 1'b0;
                active = 1'b1;
                grants.push_back(1'b1);
            end
            if (kw_valid && kw_ready) begin
                prio_st = 1'b1;
                active = 1'b1;
                grants.push_back(1'b0);
            end
        end
    end

    initial begin
        #200000;
        errs++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        logic [7:0] y;
        logic [7:0] s;
        logic [2:0] ord;
        for (int x = 0; x < 256; x++) begin
            y = 8'h00;
            for (int z = 1; z < 256; z++) if (gf_mul(x[7:0], z[7:0]) == 8'h01) y = z[7:0];
            s = affine(y);
            fwd_t[x] = s;
            inv_t[s] = x[7:0];
        end

        // reset state, with both valids high to confirm no grant under reset
        repeat (3) @(posedge clk);
        #1;
        st_valid = 1'b1;
        kw_valid = 1'b1;
        #1;
        chk("rst_st_ready", st_ready, 0);
        chk("rst_kw_ready", kw_ready, 0);
        chk("rst_st_out", st_out, 0);
        chk("rst_kw_out", kw_out, 0);
        chk("rst_st_done", st_done, 0);
        chk("rst_kw_done", kw_done, 0);
        chk("rst_busy", busy, 0);
        st_valid = 1'b0;
        kw_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // simultaneous requests: kw first, then state, then state wins over pending kw
        fork
            begin
                kw_job(32'h03020100, 32'h7b777c63);
                kw_job(32'h00000000, 32'h63636363);
            end
            st_job('0, 1'b0, {16{8'h63}});
        join
        drain();
        chk("grant_count", grants.size(), 3);
        if (grants.size() >= 3) begin
            ord = {grants[0], grants[1], grants[2]};
            chk("grant_order", ord, 3'b010);
        end
        if (kw_done_log.size() >= 1) chk("st_after_kw_done", st_acc, kw_done_log[0] + 1);
        else chk("kw_done_seen", 0, 1);

        // inverse and byte-lane known answers
        @(posedge clk);
        #1;
        st_job({16{8'h63}}, 1'b1, '0);
        st_job(128'h0f0e0d0c0b0a09080706050403020100, 1'b0,
               128'h76abd7fe2b670130c56f6bf27b777c63);
        drain();

        // randomized contention between both requesters
        @(posedge clk);
        #1;
        fork
            begin
                logic [127:0] d;
                logic dec;
                for (int j = 0; j < 25; j++) begin
                    repeat ($urandom_range(0, 4)) @(posedge clk);
                    #1;
                    d = {$urandom, $urandom, $urandom, $urandom};
                    dec = 1'($urandom_range(0, 1));
                    st_job(d, dec, st_model(d, dec));
                end
            end
            begin
                logic [31:0] w;
                for (int j = 0; j < 40; j++) begin
                    repeat ($urandom_range(0, 6)) @(posedge clk);
                    #1;
                    w = $urandom;
                    kw_job(w, kw_model(w));
                end
            end
        join
        drain();

        // reset in the middle of a state job aborts it
        @(posedge clk);
        #1;
        st_job({$urandom, $urandom, $urandom, $urandom}, 1'b0, '0);
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        st_valid = 1'b1;
        kw_valid = 1'b1;
        #2;
        chk("abort_st_out", st_out, 0);
        chk("abort_kw_out", kw_out, 0);
        chk("abort_busy", busy, 0);
        chk("abort_st_done", st_done, 0);
        chk("abort_st_ready", st_ready, 0);
        chk("abort_kw_ready", kw_ready, 0);
        @(posedge clk);
        #1;
        st_valid = 1'b0;
        kw_valid = 1'b0;
        rst_n = 1'b1;
        kw_job(32'h00000000, 32'h63636363);
        drain();
        repeat (20) @(posedge clk);
        chk("st_q_empty", st_q.size(), 0);
        chk("kw_q_empty", kw_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
